// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM input and measurement result bundle for pwm_capture
interface pwm_capture_if #(
  parameter int CTR_W = 11
);
  logic             pwm_i;
  logic             new_sample;
  logic [CTR_W-1:0] high_time;
  logic [CTR_W-1:0] period;
  logic             stuck_high;
  logic             stuck_low;

  modport master (
    output pwm_i,
    input  new_sample, high_time, period, stuck_high, stuck_low
  );

  modport slave (
    input  pwm_i,
    output new_sample, high_time, period, stuck_high, stuck_low
  );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period / high-time capture with stuck-level detection
module pwm_capture #(
  parameter int CTR_W   = 11,
  parameter int TIMEOUT = 2000
) (
  input  logic                clk,
  input  logic                rst,
  pwm_capture_if.slave        io_pwm
);

  localparam logic [0:0]       ST_ACQ    = 1'b0;
  localparam logic [0:0]       ST_MEAS   = 1'b1;
  localparam logic [CTR_W-1:0] CTR_MAX   = '1;
  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
  localparam logic [CTR_W-1:0] TIMEOUT_C = CTR_W'(TIMEOUT);

  logic             r_s1, r_s2, r_s3;
  logic             r_rise;
  logic [0:0]       r_state;
  logic [CTR_W-1:0] r_cnt;
  logic [CTR_W-1:0] r_hcnt;
  logic [CTR_W-1:0] r_period;
  logic [CTR_W-1:0] r_high_time;
  logic             r_new_sample;
  logic             r_stuck_high;
  logic             r_stuck_low;
  logic             w_rise;

  assign w_rise = r_s2 & ~r_s3;

  // The FSM acts on the registered rise one cycle later; high cycles are
  // therefore counted from s3 (s2 delayed by one) so both stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_rise       <= 1'b0;
      r_state      <= ST_ACQ;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_new_sample <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else begin
      r_s1         <= io_pwm.pwm_i;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_rise       <= w_rise;
      r_new_sample <= 1'b0;
      case (r_state)
        ST_ACQ: begin
          if (r_rise) begin
            r_cnt        <= CTR_ONE;
            r_hcnt       <= CTR_ONE;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
            r_state      <= ST_MEAS;
          end
        end
        ST_MEAS: begin
          if (r_rise) begin
            r_period     <= r_cnt;
            r_high_time  <= r_hcnt;
            r_new_sample <= 1'b1;
            r_cnt        <= CTR_ONE;
            r_hcnt       <= CTR_ONE;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
          end else if (r_cnt == TIMEOUT_C) begin
            r_stuck_high <= r_s2;
            r_stuck_low  <= ~r_s2;
            r_state      <= ST_ACQ;
          end else begin
            if (r_cnt != CTR_MAX) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (r_s3 && (r_hcnt != CTR_MAX)) begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_ACQ;
      endcase
    end
  end

  assign io_pwm.new_sample = r_new_sample;
  assign io_pwm.period     = r_period;
  assign io_pwm.high_time  = r_high_time;
  assign io_pwm.stuck_high = r_stuck_high;
  assign io_pwm.stuck_low  = r_stuck_low;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int CTR_W   = 11;
  localparam int TIMEOUT = 2000;

  logic clk = 1'b0;
  logic rst;

  pwm_capture_if #(.CTR_W(CTR_W)) pif ();

  pwm_capture #(.CTR_W(CTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_pwm (pif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log written only by the monitor; the main flow reads it relative to marks.
  int   ns_cyc[$];
  int   ns_per[$];
  int   ns_hi[$];
  int   sl_rise[$];
  int   sh_rise[$];
  int   rise_k[$];
  int   wide_cnt = 0;
  int   both_cnt = 0;
  int   stuck_seen = 0;
  logic prev_ns = 1'b0;
  logic prev_sl = 1'b0;
  logic prev_sh = 1'b0;

  always @(negedge clk) begin
    if (pif.new_sample === 1'b1) begin
      ns_cyc.push_back(cyc);
      ns_per.push_back(int'(pif.period));
      ns_hi.push_back(int'(pif.high_time));
      if (prev_ns) wide_cnt = wide_cnt + 1;
    end
    if (pif.stuck_low === 1'b1 && !prev_sl) sl_rise.push_back(cyc);
    if (pif.stuck_high === 1'b1 && !prev_sh) sh_rise.push_back(cyc);
    if (pif.stuck_high === 1'b1 && pif.stuck_low === 1'b1) both_cnt = both_cnt + 1;
    if (pif.stuck_high === 1'b1 || pif.stuck_low === 1'b1) stuck_seen = stuck_seen + 1;
    prev_ns = (pif.new_sample === 1'b1);
    prev_sl = (pif.stuck_low === 1'b1);
    prev_sh = (pif.stuck_high === 1'b1);
  end

  int b_ns, b_rise, b_sl, b_sh, b_wide, b_both, b_stuck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    #1;
    b_ns    = ns_cyc.size();
    b_rise  = rise_k.size();
    b_sl    = sl_rise.size();
    b_sh    = sh_rise.size();
    b_wide  = wide_cnt;
    b_both  = both_cnt;
    b_stuck = stuck_seen;
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (v && !pif.pwm_i) rise_k.push_back(cyc + 1);
      pif.pwm_i = v;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic tail();
    drive(1'b1, 5);
    drive(1'b0, 5);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    pif.pwm_i = 1'b0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_new_sample"}, pif.new_sample, 0);
    check({tag, "_period"}, pif.period, 0);
    check({tag, "_high_time"}, pif.high_time, 0);
    check({tag, "_stuck_high"}, pif.stuck_high, 0);
    check({tag, "_stuck_low"}, pif.stuck_low, 0);
  endtask

  // Pulse i of a clean train belongs to rise i+1 (rise 0 only arms) and
  // appears three edges after the edge that first sampled that rise.
  task automatic check_train(input string tag, input int n, input int per, input int hi);
    int got_n;
    got_n = ns_cyc.size() - b_ns;
    check({tag, "_count"}, got_n, n);
    for (int i = 0; i < n && i < got_n; i++) begin
      check($sformatf("%s_period%0d", tag, i), ns_per[b_ns + i], per);
      check($sformatf("%s_high%0d", tag, i), ns_hi[b_ns + i], hi);
      check($sformatf("%s_lat%0d", tag, i), ns_cyc[b_ns + i], rise_k[b_rise + i + 1] + 3);
    end
  endtask

  task automatic check_clean(input string tag);
    check({tag, "_wide_pulse"}, wide_cnt - b_wide, 0);
    check({tag, "_both_stuck"}, both_cnt - b_both, 0);
    check({tag, "_stuck_seen"}, stuck_seen - b_stuck, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int duty_exp[4];
    int got_n;
    duty_exp = '{300, 300, 1000, 1000};
    rst = 1'b1;
    pif.pwm_i = 1'b0;

    do_reset(3);
    #1;
    check_outputs_zero("reset");

    mark();
    wave(300, 950, 4);
    tail();
    check_train("basic", 4, 1250, 300);
    check_clean("basic");

    do_reset(1);
    mark();
    wave(300, 950, 2);
    wave(1000, 250, 2);
    tail();
    got_n = ns_cyc.size() - b_ns;
    check("duty_count", got_n, 4);
    for (int i = 0; i < 4 && i < got_n; i++) begin
      check($sformatf("duty_period%0d", i), ns_per[b_ns + i], 1250);
      check($sformatf("duty_high%0d", i), ns_hi[b_ns + i], duty_exp[i]);
    end
    check_clean("duty");

    do_reset(1);
    mark();
    wave(300, TIMEOUT - 300, 2);
    tail();
    check_train("tmo_edge", 2, TIMEOUT, 300);
    check_clean("tmo_edge");

    do_reset(1);
    mark();
    wave(300, 950, 2);
    drive(1'b1, 300);
    drive(1'b0, 2100);
    #1;
    check("slow_flag_count", sl_rise.size() - b_sl, 1);
    if (sl_rise.size() > b_sl)
      check("slow_when", sl_rise[b_sl], rise_k[b_rise + 2] + TIMEOUT + 3);
    check("slow_stuck_low", pif.stuck_low, 1);
    check("slow_stuck_high", pif.stuck_high, 0);
    check("slow_period_hold", pif.period, 1250);
    check("slow_high_hold", pif.high_time, 300);
    check("slow_pulses", ns_cyc.size() - b_ns, 2);
    drive(1'b1, 300);
    #1;
    check("slow_clear", pif.stuck_low, 0);
    check("slow_no_pulse_arm", ns_cyc.size() - b_ns, 2);
    drive(1'b0, 950);
    tail();
    check("slow_resume_pulses", ns_cyc.size() - b_ns, 3);
    check("slow_resume_period", ns_per[ns_per.size() - 1], 1250);
    check("slow_resume_high", ns_hi[ns_hi.size() - 1], 300);
    check("slow_both", both_cnt - b_both, 0);

    do_reset(1);
    mark();
    wave(300, 950, 1);
    drive(1'b1, 2500);
    #1;
    check("shigh_flag_count", sh_rise.size() - b_sh, 1);
    if (sh_rise.size() > b_sh)
      check("shigh_when", sh_rise[b_sh], rise_k[b_rise + 1] + TIMEOUT + 3);
    check("shigh_stuck_high", pif.stuck_high, 1);
    check("shigh_stuck_low", pif.stuck_low, 0);
    check("shigh_pulses", ns_cyc.size() - b_ns, 1);
    drive(1'b0, 950);
    wave(300, 950, 1);
    tail();
    check("shigh_clear", pif.stuck_high, 0);
    check("shigh_resume_pulses", ns_cyc.size() - b_ns, 2);
    check("shigh_resume_period", ns_per[ns_per.size() - 1], 1250);
    check("shigh_resume_high", ns_hi[ns_hi.size() - 1], 300);
    check("shigh_both", both_cnt - b_both, 0);

    do_reset(1);
    mark();
    wave(300, 950, 2);
    drive(1'b1, 300);
    drive(1'b0, 300);
    check("mid_pre_pulses", ns_cyc.size() - b_ns, 2);
    do_reset(1);
    #1;
    check_outputs_zero("mid_rst");
    mark();
    drive(1'b0, 650);
    wave(300, 950, 1);
    tail();
    check_train("mid_after", 1, 1250, 300);
    check_clean("mid_after");

    do_reset(1);
    mark();
    wave(1, 1, 20);
    tail();
    check_train("min", 20, 2, 1);
    check_clean("min");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
